// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM states, oversample vote points, DATA_BITS range.
// No ports; imported by uart_rx_os and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  // Three vote samples straddle the centre of the bit period.
  function automatic int vote_lo(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int vote_mid(input int os);
    return os / 2;
  endfunction

  function automatic int vote_hi(input int os);
    return os / 2 + 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divisor counter producing a one-clk tick every div+1 clocks.
// Ports: clk, rst (sync, high), div (clocks per tick minus 1), tick.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= keeps the counter from running the full range if div shrinks
  assign tick = (cnt >= div);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, valid/ready output,
// per-word frame/parity error and sticky overrun. Optional parity: UART_RX_PARITY_EN.
// Ports: clk, rst, baud_div, rx, m_data/m_valid/m_ready, frame_err, parity_err,
//        overrun, overrun_clr, busy.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [OSW-1:0] V_LO  = OSW'(vote_lo(OVERSAMPLE));
  localparam logic [OSW-1:0] V_MID = OSW'(vote_mid(OVERSAMPLE));
  localparam logic [OSW-1:0] V_HI  = OSW'(vote_hi(OVERSAMPLE));
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_bits
    $error("uart_rx_os: DATA_BITS out of range");
  end

  logic tick;

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .div (baud_div),
    .tick(tick)
  );

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  rx_state_t            state;
  logic [OSW-1:0]       os_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 smp0, smp1;
  logic                 fall, maj, take;

  assign fall = s3 & ~s2;
  // third sample is the live synchronised value at the V_HI tick
  assign maj  = (smp0 & smp1) | (smp0 & s2) | (smp1 & s2);
  assign take = ~m_valid | m_ready;
  assign busy = (state != RX_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      smp0      <= 1'b1;
      smp1      <= 1'b1;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      if (overrun_clr)
        overrun <= 1'b0;
      if (m_valid && m_ready)
        m_valid <= 1'b0;

      if (tick && state != RX_IDLE) begin
        if (os_cnt == V_LO)
          smp0 <= s2;
        if (os_cnt == V_MID)
          smp1 <= s2;
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
      end

      unique case (state)
        RX_IDLE: begin
          if (fall) begin
            os_cnt <= '0;
            state  <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (os_cnt == V_HI && maj)
              state <= RX_IDLE;
            else if (os_cnt == OS_LAST) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (os_cnt == V_HI)
              shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (os_cnt == OS_LAST) begin
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= RX_PARITY;
`else
                state <= RX_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        RX_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick) begin
            if (os_cnt == V_HI)
              par_bit <= maj;
            if (os_cnt == OS_LAST)
              state <= RX_STOP;
          end
`else
          state <= RX_IDLE;
`endif
        end
        RX_STOP: begin
          // finish at the vote, half a bit early, to catch back-to-back starts
          if (tick && os_cnt == V_HI) begin
            state <= RX_IDLE;
            if (take) begin
              m_data    <= shreg;
              frame_err <= ~maj;
              m_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= ((^shreg) ^ par_bit) != 1'(PARITY_ODD);
`endif
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: table of frames plus hand sequences for
// glitch, break, overrun, mid-frame reset and a 5-bit instance.
module tb_uart_rx_os;

  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx, rx5;
  logic        m_ready, overrun_clr;

  logic [7:0] m_data;
  logic       m_valid, frame_err, parity_err, overrun, busy;
  logic [4:0] m_data5;
  logic       m_valid5, frame_err5, parity_err5, overrun5, busy5;
  logic       ready5 = 1'b1;
  logic       clr5 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_os #(
    .DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16), .PARITY_ODD(1)
  ) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );

  uart_rx_os #(
    .DATA_BITS(5), .OVERSAMPLE(16), .DIV_W(16), .PARITY_ODD(1)
  ) dut5 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx5),
    .m_data(m_data5), .m_valid(m_valid5), .m_ready(ready5),
    .frame_err(frame_err5), .parity_err(parity_err5),
    .overrun(overrun5), .overrun_clr(clr5), .busy(busy5)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } word_t;

  typedef struct {
    logic [7:0] d;
    logic       stp;
    logic [7:0] ed;
    logic       efe;
  } vec_t;

  word_t q[$];
  word_t q5[$];
  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready)
      q.push_back('{m_data, frame_err, parity_err});
    if (!rst && m_valid5)
      q5.push_back('{{3'b000, m_data5}, frame_err5, parity_err5});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input bit to5);
    if (to5) rx5 = v;
    else rx = v;
    clks(BIT_CLKS);
  endtask

  function automatic logic odd_par(input logic [7:0] d, input int nb);
    logic x;
    x = 1'b0;
    for (int i = 0; i < nb; i++) x ^= d[i];
    return ~x;
  endfunction

  task automatic send(input logic [7:0] d, input int nb, input logic par,
                      input logic stp, input bit to5);
    drive(1'b0, to5);
    for (int i = 0; i < nb; i++) drive(d[i], to5);
`ifdef UART_RX_PARITY_EN
    drive(par, to5);
`else
    if (par === 1'bx) drive(1'b1, to5);
`endif
    drive(stp, to5);
    if (to5) rx5 = 1'b1;
    else rx = 1'b1;
  endtask

  task automatic chk_word(input string name, input logic [7:0] ed,
                          input logic efe, input logic epe);
    word_t w;
    chk({name, "_count"}, q.size(), 1);
    if (q.size() > 0) begin
      w = q.pop_front();
      chk({name, "_data"}, w.d, ed);
      chk({name, "_ferr"}, w.fe, efe);
      chk({name, "_perr"}, w.pe, epe);
    end
    q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v[5];
    word_t w;
    v[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    v[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    v[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    v[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    v[4] = '{8'h81, 1'b1, 8'h81, 1'b0};

    rst = 1'b1;
    rx = 1'b1;
    rx5 = 1'b1;
    baud_div = 16'd3;
    m_ready = 1'b1;
    overrun_clr = 1'b0;
    clks(4);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    clks(BIT_CLKS);

    for (int i = 0; i < 5; i++) begin
      q.delete();
      send(v[i].d, 8, odd_par(v[i].d, 8), v[i].stp, 1'b0);
      clks(32);
      chk_word($sformatf("vec%0d", i), v[i].ed, v[i].efe, 1'b0);
      chk($sformatf("vec%0d_overrun", i), overrun, 0);
      chk($sformatf("vec%0d_valid_low", i), m_valid, 0);
    end

    q.delete();
    rx = 1'b0;
    clks(16);
    rx = 1'b1;
    clks(4);
    chk("glitch_busy_high", busy, 1);
    clks(64);
    chk("glitch_busy_low", busy, 0);
    chk("glitch_no_word", q.size(), 0);
    clks(BIT_CLKS);

    q.delete();
    rx = 1'b0;
    clks(20 * BIT_CLKS);
    rx = 1'b1;
    clks(2 * BIT_CLKS);
    chk_word("break", 8'h00, 1'b1, 1'b0);
    chk("break_idle", busy, 0);

    q.delete();
    m_ready = 1'b0;
    send(8'h11, 8, odd_par(8'h11, 8), 1'b1, 1'b0);
    send(8'h22, 8, odd_par(8'h22, 8), 1'b1, 1'b0);
    clks(32);
    chk("ovr_valid", m_valid, 1);
    chk("ovr_data_held", m_data, 8'h11);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_no_handshake", q.size(), 0);
    overrun_clr = 1'b1;
    clks(1);
    overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    chk("ovr_valid_kept", m_valid, 1);
    m_ready = 1'b1;
    clks(3);
    chk("ovr_valid_drop", m_valid, 0);
    chk_word("ovr_word", 8'h11, 1'b0, 1'b0);

    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    rst = 1'b1;
    rx = 1'b1;
    clks(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", m_data, 0);
    chk("midrst_valid", m_valid, 0);
    rst = 1'b0;
    q.delete();
    clks(2 * BIT_CLKS);
    chk("midrst_no_word", q.size(), 0);
    send(8'h5A, 8, odd_par(8'h5A, 8), 1'b1, 1'b0);
    clks(32);
    chk_word("after_rst", 8'h5A, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 8, 1'b0, 1'b1, 1'b0);
    clks(32);
    chk_word("par_ok", 8'h07, 1'b0, 1'b0);
    send(8'h07, 8, 1'b1, 1'b1, 1'b0);
    clks(32);
    chk_word("par_bad", 8'h07, 1'b0, 1'b1);
`endif

    q5.delete();
    send(8'h1F, 5, odd_par(8'h1F, 5), 1'b1, 1'b1);
    clks(32);
    chk("bits5_count", q5.size(), 1);
    if (q5.size() > 0) begin
      w = q5.pop_front();
      chk("bits5_data", w.d, 8'h1F);
      chk("bits5_ferr", w.fe, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
